// File: rtl/spi_slave_sync.sv
// spi_slave_sync
//
// SPI slave endpoint clocked entirely by the system clock. SCLK, LOAD and
// MOSI are oversampled through SYNC-deep synchronizers. Edges are found by
// comparing the last synchronizer stage with one extra delay flop. One M-bit
// word is exchanged per frame, MSB first.
//
// Ports:
//    clk      - system clock
//    rst_n    - asynchronous active-low reset
//    SCLK     - serial clock from the master (idle low)
//    LOAD     - frame strobe; low while a frame is active, its rise ends the frame
//    MOSI     - serial data from the master
//    MISO     - serial data to the master (0 outside a frame)
//    tx_dat   - next word to transmit
//    tx_we    - one-cycle write strobe for tx_dat into the TX holding register
//    rx_dat   - last correctly received word
//    rx_valid - one-cycle pulse when rx_dat is updated
//    rx_err   - one-cycle pulse when a frame ends with a bit count other than M
//    busy     - high while a frame is being shifted
module spi_slave_sync #(
   parameter int M    = 9,
   parameter int SYNC = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         SCLK,
   input  logic         LOAD,
   input  logic         MOSI,
   output logic         MISO,
   input  logic [M-1:0] tx_dat,
   input  logic         tx_we,
   output logic [M-1:0] rx_dat,
   output logic         rx_valid,
   output logic         rx_err,
   output logic         busy
);

   localparam int CW = $clog2(M + 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;

   logic [SYNC-1:0] sclk_sync_r;
   logic [SYNC-1:0] load_sync_r;
   logic [SYNC-1:0] mosi_sync_r;
   logic            sclk_d_r;
   logic            load_d_r;

   logic            sclk_rise_s;
   logic            sclk_fall_s;
   logic            load_rise_s;
   logic            load_fall_s;
   logic            mosi_s;

   logic [M-1:0]    tx_hold_r;
   logic [M-1:0]    tx_sh_r;
   logic [M-1:0]    rx_sh_r;
   logic [CW-1:0]   cnt_r;
   logic [M-1:0]    rx_dat_r;
   logic            rx_valid_r;
   logic            rx_err_r;
   logic            miso_r;
   logic            busy_r;

   // Input synchronizers plus one delay flop on SCLK and LOAD for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_r <= '0;
         load_sync_r <= '0;
         mosi_sync_r <= '0;
         sclk_d_r    <= 1'b0;
         load_d_r    <= 1'b0;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC-2:0], SCLK};
         load_sync_r <= {load_sync_r[SYNC-2:0], LOAD};
         mosi_sync_r <= {mosi_sync_r[SYNC-2:0], MOSI};
         sclk_d_r    <= sclk_sync_r[SYNC-1];
         load_d_r    <= load_sync_r[SYNC-1];
      end
   end

   // Edge decode from the synchronized stage against its delayed copy.
   always_comb begin
      sclk_rise_s = sclk_sync_r[SYNC-1] & ~sclk_d_r;
      sclk_fall_s = ~sclk_sync_r[SYNC-1] & sclk_d_r;
      load_rise_s = load_sync_r[SYNC-1] & ~load_d_r;
      load_fall_s = ~load_sync_r[SYNC-1] & load_d_r;
      mosi_s      = mosi_sync_r[SYNC-1];
   end

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame state transitions.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_fall_s) begin
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (load_rise_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Shift datapath, TX holding register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_hold_r  <= '0;
         tx_sh_r    <= '0;
         rx_sh_r    <= '0;
         cnt_r      <= '0;
         rx_dat_r   <= '0;
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
         miso_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
         busy_r     <= (state_nxt_s == ST_SHIFT);

         // A write during a frame only lands in the holding register, so the
         // word already loaded into tx_sh keeps shifting out untouched.
         if (tx_we) begin
            tx_hold_r <= tx_dat;
         end

         case (state_r)
            ST_IDLE: begin
               if (load_fall_s) begin
                  tx_sh_r <= tx_hold_r;
                  miso_r  <= tx_hold_r[M-1];
                  cnt_r   <= '0;
               end else begin
                  miso_r  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // LOAD rise has priority: an SCLK edge in the same cycle is dropped.
               if (load_rise_s) begin
                  miso_r <= 1'b0;
               end else if (sclk_rise_s) begin
                  rx_sh_r <= {rx_sh_r[M-2:0], mosi_s};
                  if (cnt_r != CW'(M + 1)) begin
                     cnt_r <= cnt_r + CW'(1);
                  end else begin
                     cnt_r <= cnt_r;
                  end
               end else if (sclk_fall_s) begin
                  tx_sh_r <= {tx_sh_r[M-2:0], 1'b0};
                  miso_r  <= tx_sh_r[M-2];
               end else begin
                  miso_r  <= miso_r;
               end
            end
            ST_DONE: begin
               miso_r <= 1'b0;
               if (cnt_r == CW'(M)) begin
                  rx_dat_r   <= rx_sh_r;
                  rx_valid_r <= 1'b1;
               end else begin
                  rx_err_r   <= 1'b1;
               end
            end
            default: begin
               miso_r <= 1'b0;
            end
         endcase
      end
   end

   assign MISO     = miso_r;
   assign rx_dat   = rx_dat_r;
   assign rx_valid = rx_valid_r;
   assign rx_err   = rx_err_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Testbench for spi_slave_sync: drives SPI frames as a master would, pushes
// the expected outcome of each frame into a scoreboard queue, and pops and
// compares it when the DUT pulses rx_valid or rx_err.
module tb_spi_slave_sync;

   localparam int M    = 9;
   localparam int SYNC = 2;
   localparam int H    = 5;   // SCLK half-period in clk cycles

   logic         clk;
   logic         rst_n;
   logic         SCLK;
   logic         LOAD;
   logic         MOSI;
   logic         MISO;
   logic [M-1:0] tx_dat;
   logic         tx_we;
   logic [M-1:0] rx_dat;
   logic         rx_valid;
   logic         rx_err;
   logic         busy;

   typedef struct packed {
      logic         is_err;
      logic [M-1:0] rx;
      logic [M-1:0] tx;
      logic         chk_tx;
   } sb_t;

   sb_t          sb_q[$];
   int           total;
   int           bad;
   int           cyc;
   int           rise_cyc;
   logic [M-1:0] miso_word_last;
   logic [M-1:0] tx_hold_m;
   logic [M-1:0] last_rx_m;
   logic         prev_pulse;

   spi_slave_sync #(.M(M), .SYNC(SYNC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SCLK     (SCLK),
      .LOAD     (LOAD),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .tx_dat   (tx_dat),
      .tx_we    (tx_we),
      .rx_dat   (rx_dat),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tx(input logic [M-1:0] d);
      @(negedge clk);
      tx_dat = d;
      tx_we  = 1'b1;
      @(negedge clk);
      tx_we  = 1'b0;
      tx_hold_m = d;
   endtask

   // One SCLK pulse with the given MOSI bit (no MISO capture).
   task automatic sclk_bit(input logic b);
      MOSI = b;
      wait_cyc(H);
      SCLK = 1'b1;
      wait_cyc(H);
      SCLK = 1'b0;
   endtask

   // Full master frame: n SCLK pulses sending bits[n-1:0] MSB first.
   // we_at >= 0 pulses tx_we with we_dat during the low half of that bit.
   task automatic frame(input logic [15:0] bits, input int n, input int we_at,
                        input logic [M-1:0] we_dat, input int gap);
      sb_t          it;
      logic [M-1:0] r;
      logic [M-1:0] cap;
      r = '0;
      for (int i = 0; i < n; i++) r = {r[M-2:0], bits[n-1-i]};
      it.is_err = (n != M);
      it.chk_tx = (n == M);
      it.tx     = tx_hold_m;
      if (n == M) last_rx_m = r;
      it.rx     = last_rx_m;
      sb_q.push_back(it);

      cap  = '0;
      LOAD = 1'b0;
      wait_cyc(SYNC);
      chk("busy_before_latency", {31'd0, busy}, 32'd0);
      wait_cyc(1);
      chk("busy_at_latency", {31'd0, busy}, 32'd1);
      wait_cyc(2);
      for (int i = 0; i < n; i++) begin
         MOSI = bits[n-1-i];
         if (i == we_at) begin
            tx_dat = we_dat;
            tx_we  = 1'b1;
            wait_cyc(1);
            tx_we  = 1'b0;
            tx_hold_m = we_dat;
            wait_cyc(H - 1);
         end else begin
            wait_cyc(H);
         end
         if (i < M) cap[M-1-i] = MISO;
         SCLK = 1'b1;
         wait_cyc(H);
         SCLK = 1'b0;
      end
      wait_cyc(H);
      miso_word_last = cap;
      LOAD     = 1'b1;
      rise_cyc = cyc;
      wait_cyc(gap);
   endtask

   // Scoreboard consumer: every rx_valid/rx_err pulse pops one expected frame.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid || rx_err) begin
            chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (sb_q.size() == 0) begin
               chk("pulse_without_frame", {31'd0, rx_valid | rx_err}, 32'd0);
            end else begin
               sb_t it;
               it = sb_q.pop_front();
               chk("rx_err", {31'd0, rx_err}, {31'd0, it.is_err});
               chk("rx_valid", {31'd0, rx_valid}, {31'd0, ~it.is_err});
               chk("rx_dat", {23'd0, rx_dat}, {23'd0, it.rx});
               chk("pulse_latency", cyc - rise_cyc, SYNC + 2);
               if (it.chk_tx) chk("miso_word", {23'd0, miso_word_last}, {23'd0, it.tx});
            end
         end
         prev_pulse = rx_valid | rx_err;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   initial begin
      total = 0; bad = 0; cyc = 0; rise_cyc = 0;
      miso_word_last = '0; tx_hold_m = '0; last_rx_m = '0; prev_pulse = 1'b0;
      rst_n = 1'b0; SCLK = 1'b0; LOAD = 1'b1; MOSI = 1'b0;
      tx_dat = '0; tx_we = 1'b0;
      wait_cyc(3);
      chk("reset_rx_dat", {23'd0, rx_dat}, 32'd0);
      chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_rx_err", {31'd0, rx_err}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_miso", {31'd0, MISO}, 32'd0);
      rst_n = 1'b1;
      wait_cyc(8);

      // Basic exchange.
      write_tx(9'b111011011);
      frame(16'h017A, 9, -1, 9'h000, 10);
      // Short frame, then long frame: both errors, rx_dat held.
      frame(16'h0015, 5, -1, 9'h000, 10);
      frame(16'h05A5, 11, -1, 9'h000, 10);
      // Mid-frame TX write only affects the following frame.
      write_tx(9'h155);
      frame(16'h00F3, 9, 3, 9'h0AA, 10);
      frame(16'h01C6, 9, -1, 9'h000, 10);
      chk("miso_idle", {31'd0, MISO}, 32'd0);

      // Reset in the middle of a frame.
      LOAD = 1'b0;
      wait_cyc(5);
      for (int i = 0; i < 4; i++) sclk_bit(i[0]);
      MOSI = 1'b1;
      wait_cyc(2);
      chk("busy_mid_frame", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_miso", {31'd0, MISO}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rx_dat", {23'd0, rx_dat}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
      tx_hold_m = '0;
      last_rx_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) sclk_bit(1'b1);
      chk("busy_after_rst_frame", {31'd0, busy}, 32'd0);
      wait_cyc(H);
      LOAD = 1'b1;
      wait_cyc(12);
      frame(16'h01FF, 9, -1, 9'h000, 10);

      // Back-to-back frames at the minimum LOAD-high gap.
      frame(16'h0123, 9, -1, 9'h000, SYNC + 3);
      frame(16'h00C5, 9, -1, 9'h000, 12);

      wait_cyc(10);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
